// File: rtl/cpu_debug_pkg.sv
// Shared types and constants for the CPU debug command bridge (system-clock side).
package cpu_debug_pkg;

  // Command sequencer states
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CAPTURE  = 2'd1,
    ISSUE    = 2'd2,
    WAIT_ACK = 2'd3
  } state_t;

  // Virtual-JTAG instruction codes, one per command channel
  localparam logic [1:0] IR_OCIMEM    = 2'd0;
  localparam logic [1:0] IR_TRACECTRL = 2'd1;
  localparam logic [1:0] IR_BREAK     = 2'd2;
  localparam logic [1:0] IR_TRACEMEM  = 2'd3;

  // Default shift-register geometry
  localparam int DEF_SR_WIDTH   = 38;
  localparam int DEF_ACTION_BIT = 34;

endpackage

// File: rtl/cpu_debug_cmd_sysclk_bridge_sync_edge.sv
// Multi-flop synchroniser for a TCK-domain level, followed by a rising-edge
// detector. The strobe is gated by 'arm' so that levels already high when
// reset releases never produce a spurious edge.
module cpu_debug_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic level,
  input  logic arm,
  output logic strobe
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   dly;

  // Shift the async level through the synchroniser, then delay one more cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync <= '0;
      dly  <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], level};
      dly  <= sync[SYNC_STAGES-1];
    end
  end

  assign strobe = sync[SYNC_STAGES-1] & ~dly & arm;

endmodule

// File: rtl/cpu_debug_cmd_sysclk_bridge.sv
// System-clock half of the CPU debug slave: synchronises update-DR/IR strobes
// from TCK, captures the scanned shift register into jdo and turns the latched
// instruction into per-channel take_action / take_no_action pulses, with an
// optional acknowledge handshake and sticky overrun / bad-instruction flags.
module cpu_debug_cmd_sysclk_bridge
  import cpu_debug_pkg::*;
#(
  parameter int SR_WIDTH    = DEF_SR_WIDTH,
  parameter int IR_WIDTH    = 2,
  parameter int NUM_CH      = 4,
  parameter int ACTION_BIT  = DEF_ACTION_BIT,
  parameter int SYNC_STAGES = 2,
  parameter int ACK_MODE    = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                vs_udr,
  input  logic                vs_uir,
  input  logic [IR_WIDTH-1:0] ir_in,
  input  logic [SR_WIDTH-1:0] sr,
  output logic [SR_WIDTH-1:0] jdo,
  output logic [NUM_CH-1:0]   take_action,
  output logic [NUM_CH-1:0]   take_no_action,
  output logic                cmd_pending,
  input  logic                cmd_ack,
  output logic                overrun,
  output logic                bad_ir,
  input  logic                err_clr
);

  localparam int                ARM_W    = $clog2(SYNC_STAGES + 2);
  localparam logic [ARM_W-1:0]  ARM_DONE = ARM_W'(SYNC_STAGES + 1);

  state_t              state;
  logic [ARM_W-1:0]    arm_cnt;
  logic                armed;
  logic                udr_stb, uir_stb;
  logic [IR_WIDTH-1:0] ir_q, cmd_ir;
  logic [NUM_CH-1:0]   ch_hit;
  logic                ir_ok, ack, accept, drop, issue;

  // Hold off edge detection until the synchronisers have flushed after reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       arm_cnt <= '0;
    else if (!armed) arm_cnt <= arm_cnt + 1'b1;
  end

  assign armed = (arm_cnt == ARM_DONE);

  cpu_debug_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_udr (
    .clk(clk), .reset(reset), .level(vs_udr), .arm(armed), .strobe(udr_stb)
  );

  cpu_debug_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_uir (
    .clk(clk), .reset(reset), .level(vs_uir), .arm(armed), .strobe(uir_stb)
  );

  // Latch the instruction on every update-IR, whatever the sequencer is doing
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        ir_q <= '0;
    else if (uir_stb) ir_q <= ir_in;
  end

  // One-hot channel decode; all-zero when the instruction has no channel
  always_comb begin
    ch_hit = '0;
    for (int i = 0; i < NUM_CH; i++) ch_hit[i] = (int'(cmd_ir) == i);
  end

  assign ir_ok  = |ch_hit;
  assign ack    = (ACK_MODE != 0) && cmd_ack;
  assign issue  = (state == ISSUE);
  // A new capture is taken when idle, or when the outstanding ack lands in
  // the same cycle; anything else is an overrun and the edge is lost.
  assign accept = udr_stb && ((state == IDLE) || ((state == WAIT_ACK) && ack));
  assign drop   = udr_stb && !accept;

  // Command sequencer and capture register; capture uses the pre-update ir_q
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      jdo    <= '0;
      cmd_ir <= '0;
    end else begin
      if (accept) begin
        jdo    <= sr;
        cmd_ir <= ir_q;
      end
      case (state)
        IDLE:     if (accept) state <= CAPTURE;
        CAPTURE:  state <= ISSUE;
        ISSUE:    state <= (ir_ok && (ACK_MODE != 0)) ? WAIT_ACK : IDLE;
        WAIT_ACK: if (ack) state <= accept ? CAPTURE : IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

  // Pulses are registered so they are high for exactly the ISSUE cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      take_action    <= '0;
      take_no_action <= '0;
    end else begin
      take_action    <= ((state == CAPTURE) &&  jdo[ACTION_BIT]) ? ch_hit : '0;
      take_no_action <= ((state == CAPTURE) && !jdo[ACTION_BIT]) ? ch_hit : '0;
    end
  end

  // Outstanding-command flag for the acknowledge handshake
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                   cmd_pending <= 1'b0;
    else if (issue && ir_ok && (ACK_MODE != 0))  cmd_pending <= 1'b1;
    else if ((state == WAIT_ACK) && ack)         cmd_pending <= 1'b0;
  end

  // Sticky error flags; a new error in the clear cycle takes priority
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun <= 1'b0;
      bad_ir  <= 1'b0;
    end else begin
      if (drop)         overrun <= 1'b1;
      else if (err_clr) overrun <= 1'b0;
      if (issue && !ir_ok) bad_ir <= 1'b1;
      else if (err_clr)    bad_ir <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cpu_debug_cmd_sysclk_bridge.sv
// Self-checking bench: three bridge instances (fire-and-forget, ack with four
// channels, ack with three channels) share one stimulus stream; a per-instance
// transaction-level model predicts capture, pulses, pending and error flags.
`timescale 1ns/1ps
module tb_cpu_debug_cmd_sysclk_bridge;
  import cpu_debug_pkg::*;

  localparam int SRW = 38;

  logic clk = 1'b0, reset = 1'b1;
  logic vs_udr = 1'b0, vs_uir = 1'b0, cmd_ack = 1'b0, err_clr = 1'b0;
  logic [1:0]     ir_in = '0;
  logic [SRW-1:0] sr = '0;

  always #5 clk = ~clk;

  logic [SRW-1:0] jdo0, jdo1, jdo2;
  logic [3:0]     ta0, tna0, ta1, tna1;
  logic [2:0]     ta2, tna2;
  logic           pend0, pend1, pend2, ovr0, ovr1, ovr2, bad0, bad1, bad2;

  cpu_debug_cmd_sysclk_bridge #(.NUM_CH(4), .ACK_MODE(0)) dut0 (
    .clk(clk), .reset(reset), .vs_udr(vs_udr), .vs_uir(vs_uir), .ir_in(ir_in), .sr(sr),
    .jdo(jdo0), .take_action(ta0), .take_no_action(tna0), .cmd_pending(pend0),
    .cmd_ack(cmd_ack), .overrun(ovr0), .bad_ir(bad0), .err_clr(err_clr));
  cpu_debug_cmd_sysclk_bridge #(.NUM_CH(4), .ACK_MODE(1)) dut1 (
    .clk(clk), .reset(reset), .vs_udr(vs_udr), .vs_uir(vs_uir), .ir_in(ir_in), .sr(sr),
    .jdo(jdo1), .take_action(ta1), .take_no_action(tna1), .cmd_pending(pend1),
    .cmd_ack(cmd_ack), .overrun(ovr1), .bad_ir(bad1), .err_clr(err_clr));
  cpu_debug_cmd_sysclk_bridge #(.NUM_CH(3), .ACK_MODE(1)) dut2 (
    .clk(clk), .reset(reset), .vs_udr(vs_udr), .vs_uir(vs_uir), .ir_in(ir_in), .sr(sr),
    .jdo(jdo2), .take_action(ta2), .take_no_action(tna2), .cmd_pending(pend2),
    .cmd_ack(cmd_ack), .overrun(ovr2), .bad_ir(bad2), .err_clr(err_clr));

  logic [SRW-1:0] jdo [3];
  logic [3:0]     ta [3], tna [3];
  logic           pend [3], ovr [3], bad [3];
  assign jdo[0] = jdo0;  assign jdo[1] = jdo1;  assign jdo[2] = jdo2;
  assign ta[0]  = ta0;   assign ta[1]  = ta1;   assign ta[2]  = {1'b0, ta2};
  assign tna[0] = tna0;  assign tna[1] = tna1;  assign tna[2] = {1'b0, tna2};
  assign pend[0] = pend0; assign pend[1] = pend1; assign pend[2] = pend2;
  assign ovr[0]  = ovr0;  assign ovr[1]  = ovr1;  assign ovr[2]  = ovr2;
  assign bad[0]  = bad0;  assign bad[1]  = bad1;  assign bad[2]  = bad2;

  // Reference model: instance configuration and expected architectural state
  int             nch [3]  = '{4, 4, 3};
  bit             ackm [3] = '{1'b0, 1'b1, 1'b1};
  logic [SRW-1:0] m_jdo [3];
  bit             m_pend [3], m_ovr [3], m_bad [3];
  logic [1:0]     m_irq;
  int             exp_pulses [3] = '{0, 0, 0};
  int             got_pulses [3] = '{0, 0, 0};
  int             multi_hot  [3] = '{0, 0, 0};

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Pulse monitor, sampled mid-cycle
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      got_pulses[d] += $countones(ta[d]) + $countones(tna[d]);
      if ($countones(ta[d] | tna[d]) > 1 || ((|ta[d]) && (|tna[d]))) multi_hot[d]++;
    end
  end

  task automatic check_all(input string where);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("%s.jdo%0d", where, d),  64'(jdo[d]),  64'(m_jdo[d]));
      chk($sformatf("%s.pend%0d", where, d), 64'(pend[d]), 64'(m_pend[d]));
      chk($sformatf("%s.ovr%0d", where, d),  64'(ovr[d]),  64'(m_ovr[d]));
      chk($sformatf("%s.bad%0d", where, d),  64'(bad[d]),  64'(m_bad[d]));
    end
  endtask

  // Asynchronous reset mid-cycle; optionally hold vs_udr high across release
  task automatic do_reset(input bit held_udr);
    #2 reset = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst.ta%0d", d),   64'(ta[d]),   64'd0);
      chk($sformatf("rst.tna%0d", d),  64'(tna[d]),  64'd0);
      chk($sformatf("rst.jdo%0d", d),  64'(jdo[d]),  64'd0);
      chk($sformatf("rst.pend%0d", d), 64'(pend[d]), 64'd0);
      chk($sformatf("rst.err%0d", d),  64'({ovr[d], bad[d]}), 64'd0);
      m_jdo[d] = '0; m_pend[d] = 0; m_ovr[d] = 0; m_bad[d] = 0;
    end
    m_irq  = '0;
    vs_udr = held_udr;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    check_all("post_rst");
    vs_udr = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic uir(input logic [1:0] nir);
    ir_in = nir; vs_uir = 1'b1;
    repeat (4) @(negedge clk);
    vs_uir = 1'b0;
    repeat (4) @(negedge clk);
    m_irq = nir;
  endtask

  task automatic ack_cmd();
    cmd_ack = 1'b1;
    @(negedge clk);
    cmd_ack = 1'b0;
    for (int d = 0; d < 3; d++) if (ackm[d]) m_pend[d] = 0;
    check_all("ack");
  endtask

  task automatic clr_err();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    for (int d = 0; d < 3; d++) begin m_ovr[d] = 0; m_bad[d] = 0; end
    check_all("clr");
  endtask

  // One update-DR edge. Optional: simultaneous update-IR, cmd_ack landing in
  // the strobe cycle, err_clr landing in the strobe cycle.
  task automatic cmd(input logic [SRW-1:0] val, input bit with_uir, input logic [1:0] nir,
                     input bit collide, input bit clr);
    logic [1:0] cir;
    logic [3:0] ea [3], ena [3];
    cir = m_irq;
    for (int d = 0; d < 3; d++) begin
      ea[d] = '0; ena[d] = '0;
      if (clr) begin m_ovr[d] = 0; m_bad[d] = 0; end
      if (collide && ackm[d]) m_pend[d] = 0;
      if (m_pend[d]) m_ovr[d] = 1;
      else begin
        m_jdo[d] = val;
        if (int'(cir) < nch[d]) begin
          if (val[34]) ea[d] = 4'b1 << cir; else ena[d] = 4'b1 << cir;
          exp_pulses[d]++;
          if (ackm[d]) m_pend[d] = 1;
        end else m_bad[d] = 1;
      end
    end
    if (with_uir) m_irq = nir;

    sr = val; vs_udr = 1'b1;
    if (with_uir) begin ir_in = nir; vs_uir = 1'b1; end
    for (int e = 1; e <= 5; e++) begin
      @(posedge clk); @(negedge clk);
      case (e)
        2: begin cmd_ack = collide; err_clr = clr; end
        3: begin
          cmd_ack = 1'b0; err_clr = 1'b0;
          for (int d = 0; d < 3; d++) chk($sformatf("cap.jdo%0d", d), 64'(jdo[d]), 64'(m_jdo[d]));
        end
        4: for (int d = 0; d < 3; d++) begin
          chk($sformatf("pulse.ta%0d", d),  64'(ta[d]),  64'(ea[d]));
          chk($sformatf("pulse.tna%0d", d), 64'(tna[d]), 64'(ena[d]));
        end
        5: begin
          for (int d = 0; d < 3; d++)
            chk($sformatf("after.pulse%0d", d), 64'({ta[d], tna[d]}), 64'd0);
          check_all("cmd");
          vs_udr = 1'b0; vs_uir = 1'b0;
        end
        default: ;
      endcase
    end
    repeat (4) @(negedge clk);
  endtask

  function automatic logic [SRW-1:0] rnd_sr();
    return SRW'({$urandom(), $urandom()});
  endfunction

  initial begin
    for (int d = 0; d < 3; d++) begin m_jdo[d] = '0; m_pend[d] = 0; m_ovr[d] = 0; m_bad[d] = 0; end
    m_irq = '0;
    @(negedge clk);
    do_reset(1'b1);                                   // vs_udr high across release

    uir(IR_BREAK);     cmd(38'h04_0000_1234, 0, 2'd0, 0, 0);   // action on ch2
    ack_cmd();
    uir(IR_OCIMEM);    cmd(38'h00_DEAD_BEEF, 0, 2'd0, 0, 0);   // no-action on ch0
    ack_cmd();
    uir(IR_TRACECTRL); cmd(rnd_sr(), 0, 2'd0, 0, 0);
    cmd(38'h1, 0, 2'd0, 0, 0);                         // overrun on ack instances
    clr_err();
    cmd(rnd_sr(), 0, 2'd0, 1, 0);                      // ack collides with edge
    ack_cmd();
    uir(IR_TRACEMEM);  cmd(rnd_sr(), 0, 2'd0, 0, 0);   // bad ir on 3-channel instance
    do_reset(1'b0);                                    // dut1 sits in WAIT_ACK here
    uir(IR_BREAK);     cmd(rnd_sr(), 1, IR_OCIMEM, 0, 0);  // simultaneous uir: old ir used
    cmd(rnd_sr(), 0, 2'd0, 0, 1);                      // clear vs new overrun: set wins
    ack_cmd();

    for (int it = 0; it < 60; it++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op <= 4)
        cmd(rnd_sr(), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
      else if (op <= 6) uir(2'($urandom_range(0, 3)));
      else if (op == 7) ack_cmd();
      else if (op == 8) clr_err();
      else              do_reset(1'($urandom_range(0, 1)));
    end

    for (int d = 0; d < 3; d++) begin
      chk($sformatf("pulse_count%0d", d), 64'(got_pulses[d]), 64'(exp_pulses[d]));
      chk($sformatf("multi_hot%0d", d),   64'(multi_hot[d]),  64'd0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_debug_cmd_sysclk_bridge.md
Name: cpu_debug_cmd_sysclk_bridge

Overview:
- System-clock half of the next-generation CPU debug slave.
- Synchronises update-DR and update-IR strobes arriving from the JTAG TCK domain, then captures the scanned shift register into jdo.
- Decodes the latched instruction into per-channel take_action / take_no_action pulses.
- Adds what the previous generation lacked: parametrised width and channel count, an optional acknowledge handshake, overrun detection and bad-instruction detection.

Parameters:
- SR_WIDTH, 38: width of the scanned shift register and of jdo.
- IR_WIDTH, 2: width of the virtual-JTAG instruction.
- NUM_CH, 4: number of command channels; must satisfy NUM_CH <= 2**IR_WIDTH.
- ACTION_BIT, 34: bit of jdo selecting action (1) or no-action (0).
- SYNC_STAGES, 2: synchroniser depth for vs_udr and vs_uir; minimum 2.
- ACK_MODE, 0: 0 = fire-and-forget, as in the previous generation; 1 = every command waits for cmd_ack.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- vs_udr  in  1  update-DR level from the TCK domain; asynchronous to clk.
- vs_uir  in  1  update-IR level from the TCK domain; asynchronous to clk.
- ir_in  in  IR_WIDTH  instruction; quasi-static, stable while vs_uir is high.
- sr  in  SR_WIDTH  shift register; quasi-static, stable while vs_udr is high.
- jdo  out  SR_WIDTH  captured shift-register contents.
- take_action  out  NUM_CH  one-cycle pulse per channel.
- take_no_action  out  NUM_CH  one-cycle pulse per channel.
- cmd_pending  out  1  command issued and not yet acknowledged (ACK_MODE=1 only).
- cmd_ack  in  1  consumer acknowledge; ignored when ACK_MODE=0.
- overrun  out  1  sticky: an update-DR edge was dropped.
- bad_ir  out  1  sticky: a command was issued with ir >= NUM_CH.
- err_clr  in  1  clears overrun and bad_ir.

Behaviour:
- Reset values: every output, register and sync flop is 0; state = IDLE.
- Arm counter:
  - Counts SYNC_STAGES+1 cycles after reset deasserts.
  - Edges are ignored until the count completes, so an input already high at reset release never fires.
- Synchroniser and edge detect:
  - vs_udr and vs_uir each pass through SYNC_STAGES flops plus one delay flop.
  - strobe = sync_out & ~delayed & armed.
- uir strobe: ir_q <= ir_in, in any state.
- State machine, states IDLE, CAPTURE, ISSUE, WAIT_ACK:
  - IDLE + udr strobe: jdo <= sr; cmd_ir <= ir_q; go to CAPTURE.
  - CAPTURE -> ISSUE, unconditionally. One registered cycle lets jdo settle for downstream decoders.
  - ISSUE, cmd_ir < NUM_CH: assert take_action[cmd_ir] if jdo[ACTION_BIT]=1, else take_no_action[cmd_ir], for exactly one cycle.
  - ISSUE, cmd_ir >= NUM_CH: no pulse; set bad_ir.
  - ISSUE, ACK_MODE=0: go to IDLE.
  - ISSUE, ACK_MODE=1 and a pulse was issued: set cmd_pending; go to WAIT_ACK.
  - ISSUE, ACK_MODE=1 and bad ir: go to IDLE.
  - WAIT_ACK + cmd_ack: clear cmd_pending; go to IDLE.
  - cmd_ack outside WAIT_ACK: ignored.
- Latency:
  - Edge 1 is the first clk edge sampling vs_udr high.
  - jdo updates at edge SYNC_STAGES+1.
  - The pulse is high after edge SYNC_STAGES+2.
- Overrun and simultaneous events:
  - udr strobe in CAPTURE, ISSUE or WAIT_ACK (without cmd_ack): dropped; jdo unchanged; overrun <= 1.
  - udr strobe in WAIT_ACK in the same cycle as cmd_ack: accepted; capture and go straight to CAPTURE; no overrun.
  - udr and uir strobes in the same cycle: ir_q updates, but the capture uses the old ir_q.
  - err_clr in the same cycle as a new error event: the set wins.
- Reset mid-operation: pulses drop immediately (asynchronous); cmd_pending cleared; re-arm sequence restarts.
- take_action and take_no_action are one-hot-or-zero together; never both asserted.

Decomposition:
- Package cpu_debug_pkg holds:
  - the state enum;
  - IR code constants (IR_OCIMEM=0, IR_TRACECTRL=1, IR_BREAK=2, IR_TRACEMEM=3);
  - default SR_WIDTH and ACTION_BIT.
- Sub-module cpu_debug_sync_edge: SYNC_STAGES synchroniser plus rising-edge detector with arm input. Instantiated twice, for udr and uir.

Test Plan:
- Basic action: reset, ACK_MODE=0; uir with ir_in=2, then udr with sr=38'h04_0000_1234 (bit34=1) -> jdo=38'h04_0000_1234 after 3 edges; take_action=4'b0100 for one cycle at edge 4; take_no_action=0.
- No-action: sr=38'h00_DEAD_BEEF with ir=0 -> take_no_action=4'b0001 one cycle; take_action stays 0.
- Acknowledge handshake: ACK_MODE=1, ir=1 -> cmd_pending=1 until cmd_ack. A second udr edge with sr=38'h1 before the ack -> overrun=1 and jdo unchanged. err_clr -> overrun=0.
- Ack-and-edge collision: ACK_MODE=1; udr edge synchronised in the same cycle as cmd_ack -> new command captured, overrun stays 0.
- Bad instruction: NUM_CH=3, ir=3 -> no pulse, bad_ir=1, cmd_pending=0.
- Reset corner cases:
  - vs_udr held high across reset release -> no capture and no pulse.
  - Reset asserted during WAIT_ACK -> all outputs 0 immediately; first new edge after re-arm processed normally.
